// File: rtl/arb_pkg.sv
// Shared definitions for the instruction/data SRAM-like arbiter:
// owner encodings, transfer-size encodings and the depth limit.
package arb_pkg;

    // Owner tag stored per accepted transaction.
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } own_e;

    // SRAM-like transfer size encodings.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Largest supported number of accepted-but-unanswered transactions.
    localparam int unsigned OUTSTANDING_MAX = 4;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order owner queue: DEPTH entries of 1 bit, read/write pointers that
// wrap modulo DEPTH, and an occupancy counter. Pop on empty is ignored;
// the caller never pushes when full.
module arb_owner_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           din,
    output logic                           head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Qualified push/pop and status flags.
    always_comb begin
        push_en = push;
        pop_en  = pop & (cnt != '0);
        full    = (cnt == CW'(DEPTH));
        empty   = (cnt == '0);
        head    = mem[rd_ptr];
    end

    // Pointer, counter and entry storage updates.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            mem    <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like arbiter: shares one downstream port between the
// instruction and data ports, with a grant lock while an address waits
// for acceptance and an in-order owner queue for response routing.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating priority when
// both ports are eligible); undefined gives fixed data-over-inst priority.
// OUTSTANDING must lie in 1..OUTSTANDING_MAX.
module sram_like_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CW = $clog2(OUTSTANDING + 1);

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_head;
    logic [CW-1:0] fifo_cnt;
    logic          push;

    logic          lock_vld;
    own_e          lock_own;
    logic          room;
    logic          inst_elig;
    logic          data_elig;
    logic          grant_vld;
    own_e          grant_own;
`ifdef ARB_ROUND_ROBIN_EN
    own_e          last_own;
`endif

    // Eligibility uses only registered occupancy, so m_data_ok never reaches m_req.
    always_comb begin
        room      = (fifo_cnt < CW'(OUTSTANDING));
        inst_elig = inst_req & room;
        data_elig = data_req & room;
    end

    // Grant selection: a held lock wins while its owner still requests.
    always_comb begin
        grant_vld = 1'b0;
        grant_own = OWN_DATA;
        if (lock_vld && ((lock_own == OWN_DATA) ? data_elig : inst_elig)) begin
            grant_vld = 1'b1;
            grant_own = lock_own;
        end else if (data_elig && inst_elig) begin
            grant_vld = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            grant_own = (last_own == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
            grant_own = OWN_DATA;
`endif
        end else if (data_elig) begin
            grant_vld = 1'b1;
            grant_own = OWN_DATA;
        end else if (inst_elig) begin
            grant_vld = 1'b1;
            grant_own = OWN_INST;
        end
    end

    // Downstream request mux; all fields zero when nothing is granted.
    always_comb begin
        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_size  = '0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (grant_vld) begin
            m_req = 1'b1;
            if (grant_own == OWN_DATA) begin
                m_wr    = data_wr;
                m_size  = data_size;
                m_wstrb = data_wstrb;
                m_addr  = data_addr;
                m_wdata = data_wdata;
            end else begin
                m_wr    = inst_wr;
                m_size  = inst_size;
                m_wstrb = inst_wstrb;
                m_addr  = inst_addr;
                m_wdata = inst_wdata;
            end
        end
    end

    // Address acceptance and response routing back to the upstream ports.
    always_comb begin
        push         = m_req & m_addr_ok & ~fifo_full;
        inst_addr_ok = m_addr_ok & grant_vld & (grant_own == OWN_INST);
        data_addr_ok = m_addr_ok & grant_vld & (grant_own == OWN_DATA);
        inst_data_ok = m_data_ok & ~fifo_empty & (own_e'(fifo_head) == OWN_INST);
        data_data_ok = m_data_ok & ~fifo_empty & (own_e'(fifo_head) == OWN_DATA);
        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;
    end

    // Grant lock: hold the owner while its address waits for m_addr_ok.
    // A withdrawn request leaves no grant to that owner, so the lock drops naturally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lock_vld <= 1'b0;
            lock_own <= OWN_INST;
        end else if (m_req && !m_addr_ok) begin
            lock_vld <= 1'b1;
            lock_own <= grant_own;
        end else begin
            lock_vld <= 1'b0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the most recent accepted owner for alternating priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_own <= OWN_INST;
        end else if (push) begin
            last_own <= grant_own;
        end
    end
`endif

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (m_data_ok),
        .din   (grant_own),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter (OUTSTANDING=2). Expected
// responses are queued when an acceptance is driven and compared when
// the downstream response is returned.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        own;   // 0 = instruction, 1 = data
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .rstn(rstn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
        inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = '0; data_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    // Drive one response from the head of the scoreboard and compare routing.
    task automatic respond(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got empty scoreboard expected pending entry", tag);
            return;
        end
        e = sb.pop_front();
        m_data_ok = 1; m_rdata = e.rdata;
        #2;
        check({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'(e.own == 1'b0));
        check({tag, "_data_data_ok"}, 32'(data_data_ok), 32'(e.own == 1'b1));
        check({tag, "_rdata"}, e.own ? data_rdata : inst_rdata, e.rdata);
        step();
        m_data_ok = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 0;
        step();
        step();
        rstn = 1;
        sb.delete();
    endtask

    initial begin
        idle_inputs();
        rstn = 0;
        step();
        step();
        #2;
        check("rst_m_req", 32'(m_req), 0);
        check("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
        rstn = 1;
        step();
        #2;
        check("post_rst_m_req", 32'(m_req), 0);
        check("post_rst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
        step();

        // Lone instruction read.
        inst_req = 1; inst_addr = 32'h1c00_0000; m_addr_ok = 1;
        #2;
        check("lone_m_req", 32'(m_req), 1);
        check("lone_m_addr", m_addr, 32'h1c00_0000);
        check("lone_inst_addr_ok", 32'(inst_addr_ok), 1);
        check("lone_data_addr_ok", 32'(data_addr_ok), 0);
        sb.push_back('{1'b0, 32'h0280_0000});
        step();
        inst_req = 0; m_addr_ok = 0;
        #2;
        check("lone_addr_ok_once", 32'(inst_addr_ok), 0);
        check("lone_no_early_ok", 32'({inst_data_ok, data_data_ok}), 0);
        step();
        respond("lone");

        // Simultaneous requests: data accepted first, then instruction.
        inst_req = 1; inst_addr = 32'h1c00_0010;
        data_req = 1; data_addr = 32'h8000_0040; data_wr = 1; data_wdata = 32'hdead_beef;
        m_addr_ok = 1;
        #2;
        check("both_data_addr_ok", 32'(data_addr_ok), 1);
        check("both_inst_addr_ok", 32'(inst_addr_ok), 0);
        check("both_m_addr", m_addr, 32'h8000_0040);
        check("both_m_wdata", m_wdata, 32'hdead_beef);
        check("both_m_wr", 32'(m_wr), 1);
        sb.push_back('{1'b1, 32'h0000_000a});
        step();
        data_req = 0; data_wr = 0;
        #2;
        check("both_inst_second", 32'(inst_addr_ok), 1);
        check("both_m_addr2", m_addr, 32'h1c00_0010);
        sb.push_back('{1'b0, 32'h0000_000b});
        step();
        inst_req = 0; m_addr_ok = 0;
        respond("both_A");
        respond("both_B");

        // Lock hold: instruction waits 3 cycles while data requests.
        inst_req = 1; inst_addr = 32'h1c00_0100; m_addr_ok = 0;
        #2;
        check("lock_c0_m_addr", m_addr, 32'h1c00_0100);
        step();
        data_req = 1; data_addr = 32'h8000_0200;
        for (int i = 1; i < 3; i++) begin
            #2;
            check("lock_hold_m_addr", m_addr, 32'h1c00_0100);
            check("lock_hold_no_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
            step();
        end
        m_addr_ok = 1;
        #2;
        check("lock_rel_inst_ok", 32'(inst_addr_ok), 1);
        check("lock_rel_data_ok", 32'(data_addr_ok), 0);
        sb.push_back('{1'b0, 32'h1111_0001});
        step();
        inst_req = 0;
        #2;
        check("lock_then_data_ok", 32'(data_addr_ok), 1);
        check("lock_then_m_addr", m_addr, 32'h8000_0200);
        sb.push_back('{1'b1, 32'h1111_0002});
        step();
        data_req = 0; m_addr_ok = 0;
        respond("lock_A");
        respond("lock_B");

        // Lock tolerates withdrawal: instruction drops req while locked.
        inst_req = 1; inst_addr = 32'h1c00_0300;
        step();
        inst_req = 0; data_req = 1; data_addr = 32'h8000_0300;
        #2;
        check("withdraw_m_addr", m_addr, 32'h8000_0300);
        m_addr_ok = 1;
        #1;
        check("withdraw_data_ok", 32'(data_addr_ok), 1);
        sb.push_back('{1'b1, 32'h2222_0001});
        step();
        data_req = 0; m_addr_ok = 0;
        respond("withdraw");

        // Full queue: two accepted reads, third blocked until a pop has landed.
        inst_req = 1; inst_addr = 32'h1c00_0400; m_addr_ok = 1;
        sb.push_back('{1'b0, 32'h3333_0001});
        step();
        inst_addr = 32'h1c00_0404;
        sb.push_back('{1'b0, 32'h3333_0002});
        step();
        inst_addr = 32'h1c00_0408;
        #2;
        check("full_m_req", 32'(m_req), 0);
        check("full_inst_addr_ok", 32'(inst_addr_ok), 0);
        respond("full_pop");
        #2;
        check("full_reopen_m_req", 32'(m_req), 1);
        check("full_reopen_addr_ok", 32'(inst_addr_ok), 1);
        sb.push_back('{1'b0, 32'h3333_0003});
        step();
        inst_req = 0; m_addr_ok = 0;
        respond("full_B");
        respond("full_C");

        // Empty queue with a stray response.
        m_data_ok = 1; m_rdata = 32'hffff_ffff;
        #2;
        check("empty_stray_ok", 32'({inst_data_ok, data_data_ok}), 0);
        step();
        m_data_ok = 0;

        // Reset mid-operation with two outstanding.
        inst_req = 1; inst_addr = 32'h1c00_0500; m_addr_ok = 1;
        step();
        step();
        do_reset();
        m_data_ok = 1;
        #2;
        check("rst_mid_stray_ok", 32'({inst_data_ok, data_data_ok}), 0);
        step();
        m_data_ok = 0;
        // Counter restarted at zero: exactly two more accepts fit.
        inst_req = 1; inst_addr = 32'h1c00_0600; m_addr_ok = 1;
        #2;
        check("rst_mid_acc1", 32'(inst_addr_ok), 1);
        sb.push_back('{1'b0, 32'h4444_0001});
        step();
        #2;
        check("rst_mid_acc2", 32'(inst_addr_ok), 1);
        sb.push_back('{1'b0, 32'h4444_0002});
        step();
        #2;
        check("rst_mid_full", 32'(m_req), 0);
        inst_req = 0; m_addr_ok = 0;
        respond("rst_mid_A");
        respond("rst_mid_B");

`ifdef ARB_ROUND_ROBIN_EN
        // Round robin: both request for four cycles, winners alternate.
        do_reset();
        inst_req = 1; inst_addr = 32'h1c00_0700;
        data_req = 1; data_addr = 32'h8000_0700;
        m_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            logic exp_own;
            exp_own = (i % 2 == 0) ? 1'b1 : 1'b0;
            if (i > 0) begin
                exp_t e;
                e = sb.pop_front();
                m_data_ok = 1; m_rdata = e.rdata;
                #2;
                check("rr_resp_data_ok", 32'(data_data_ok), 32'(e.own));
                check("rr_resp_inst_ok", 32'(inst_data_ok), 32'(!e.own));
            end else begin
                #2;
            end
            check("rr_data_addr_ok", 32'(data_addr_ok), 32'(exp_own));
            check("rr_inst_addr_ok", 32'(inst_addr_ok), 32'(!exp_own));
            sb.push_back('{exp_own, 32'h5555_0000 + 32'(i)});
            step();
            m_data_ok = 0;
        end
        inst_req = 0; data_req = 0; m_addr_ok = 0;
        respond("rr_last");
`endif

        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

endmodule
